// File: rtl/v_noc_pkg.sv
// v_noc_pkg: shared NoC types for the traffic sender (flit, request, scoreboard record).
// V_SENDER_TXN_ID_EN adds a txn_id field to the scoreboard record.
package v_noc_pkg;
    localparam int FLIT_LENGTH      = 256;
    localparam int FLIT_DATA_LENGTH = 64;
    localparam int VC_ID_NUM_MAX_W  = 2;
    localparam int VC_NUM_MAX       = 1 << VC_ID_NUM_MAX_W;
    localparam int NODE_ID_W        = 4;
    localparam int SENDER_TXN_ID_W  = 4;
    localparam int TXN_ID_LSB       = 0;

    typedef logic [FLIT_LENGTH-1:0] flit_payload_t;
    typedef logic [NODE_ID_W-1:0]   node_id_t;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } io_port_t;

    typedef struct packed {
        node_id_t                    src_id;
        logic [FLIT_DATA_LENGTH-1:0] flit_data;
`ifdef V_SENDER_TXN_ID_EN
        logic [SENDER_TXN_ID_W-1:0]  txn_id;
`endif
    } sender_info_t;

    typedef struct packed {
        flit_payload_t           flit;
        logic [VC_NUM_MAX-1:0]   vc_mask;
        io_port_t                la_routing;
    } sender_req_t;

    // First set bit of cand at or after ptr, wrapping within n VCs.
    function automatic logic [VC_ID_NUM_MAX_W-1:0] rr_first(
        input logic [VC_NUM_MAX-1:0]      cand,
        input logic [VC_ID_NUM_MAX_W-1:0] ptr,
        input int                         n
    );
        logic [VC_ID_NUM_MAX_W-1:0] k;
        rr_first = ptr;
        for (int i = n - 1; i >= 0; i--) begin
            k = VC_ID_NUM_MAX_W'((int'(ptr) + i) % n);
            if (cand[k]) rr_first = k;
        end
    endfunction
endpackage

// File: rtl/v_sender_req_fifo.sv
// v_sender_req_fifo: generic synchronous FIFO, head read straight from storage.
// Pointers carry an extra wrap bit so full/empty need no separate counter.
module v_sender_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;

    assign empty = r_wr == r_rd;
    assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign dout  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/v_sender.sv
// v_sender: traffic injector for one router inport with per-VC credits and round-robin VC pick.
// Define V_SENDER_TXN_ID_EN to stamp a wrapping transaction id into each flit and record.
module v_sender
    import v_noc_pkg::*;
#(
    parameter int VC_NUM         = 4,
    parameter int VC_DEPTH       = 2,
    parameter int REQ_FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       gen_req_vld_i,
    output logic                       gen_req_rdy_o,
    input  flit_payload_t              gen_req_flit_i,
    input  logic [VC_NUM-1:0]          gen_req_vc_mask_i,
    input  io_port_t                   gen_req_look_ahead_routing_i,
    output logic                       tx_flit_pend_o,
    output logic                       tx_flit_v_o,
    output flit_payload_t              tx_flit_o,
    output logic [VC_ID_NUM_MAX_W-1:0] tx_flit_vc_id_o,
    output io_port_t                   tx_flit_look_ahead_routing_o,
    input  logic                       tx_lcrd_v_i,
    input  logic [VC_ID_NUM_MAX_W-1:0] tx_lcrd_id_i,
    output logic                       record_scoreboard_vld_o,
    output sender_info_t               record_scoreboard_o,
    input  logic                       record_scoreboard_rdy_i,
    input  node_id_t                   node_id_i,
    output logic                       idle_o,
    output logic                       err_o
);
    localparam int             CW      = $clog2(VC_DEPTH + 1);
    localparam logic [CW-1:0]  CRD_MAX = CW'(VC_DEPTH);

    logic [CW-1:0]              r_credit [VC_NUM];
    logic [CW-1:0]              w_crd_nxt [VC_NUM];
    logic [VC_ID_NUM_MAX_W-1:0] r_rr_ptr;
    logic                       r_err;
    logic                       r_tx_v;
    flit_payload_t              r_tx_flit;
    logic [VC_ID_NUM_MAX_W-1:0] r_tx_vc;
    io_port_t                   r_tx_la;
    sender_info_t               r_rec;

    sender_req_t                w_req_in;
    sender_req_t                w_head;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_drop;
    logic                       w_disp;
    logic [VC_NUM_MAX-1:0]      w_cand;
    logic [VC_ID_NUM_MAX_W-1:0] w_vc;
    logic [31:0]                w_lcrd_id;
    logic                       w_lcrd_bad;
    logic [VC_NUM-1:0]          w_inc;
    logic [VC_NUM-1:0]          w_dec;
    logic [VC_NUM-1:0]          w_ovf;
    logic                       w_crd_full;
    logic                       w_err_evt;
    flit_payload_t              w_flit;
    sender_info_t               w_rec;

    assign w_req_in = '{flit: gen_req_flit_i,
                        vc_mask: VC_NUM_MAX'(gen_req_vc_mask_i),
                        la_routing: gen_req_look_ahead_routing_i};
    assign w_push   = gen_req_vld_i && gen_req_rdy_o;
    // A pop frees the slot the push lands in, so a full FIFO still accepts then.
    assign gen_req_rdy_o = !w_full || w_pop;

    v_sender_req_fifo #(
        .WIDTH($bits(sender_req_t)),
        .DEPTH(REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .din   (w_req_in),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_head)
    );

    always_comb begin
        w_cand     = '0;
        w_crd_full = 1'b1;
        for (int v = 0; v < VC_NUM; v++) begin
            w_cand[v]  = w_head.vc_mask[v] && (r_credit[v] != '0);
            w_crd_full = w_crd_full && (r_credit[v] == CRD_MAX);
        end
    end

    assign w_drop = !w_empty && (w_head.vc_mask[VC_NUM-1:0] == '0);
    assign w_disp = !w_empty && (w_cand != '0) && record_scoreboard_rdy_i;
    assign w_pop  = w_disp || w_drop;
    assign w_vc   = rr_first(w_cand, r_rr_ptr, VC_NUM);

    // A return on a full counter is only legal when the same VC spends a credit this cycle.
    always_comb begin
        w_lcrd_id  = 32'(tx_lcrd_id_i);
        w_lcrd_bad = tx_lcrd_v_i && (w_lcrd_id >= 32'(VC_NUM));
        for (int v = 0; v < VC_NUM; v++) begin
            w_inc[v]     = tx_lcrd_v_i && (w_lcrd_id == 32'(v));
            w_dec[v]     = w_disp && (32'(w_vc) == 32'(v));
            w_ovf[v]     = w_inc[v] && (r_credit[v] == CRD_MAX) && !w_dec[v];
            w_crd_nxt[v] = r_credit[v] + CW'(w_inc[v] && !w_ovf[v]) - CW'(w_dec[v]);
        end
        w_err_evt = w_drop || w_lcrd_bad || (w_ovf != '0);
    end

`ifdef V_SENDER_TXN_ID_EN
    logic [SENDER_TXN_ID_W-1:0] r_txn;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_txn <= '0;
        else if (w_disp) r_txn <= r_txn + 1'b1;
    end

    always_comb begin
        w_flit = w_head.flit;
        w_flit[TXN_ID_LSB +: SENDER_TXN_ID_W] = r_txn;
        w_rec = '{src_id: node_id_i,
                  flit_data: w_head.flit[FLIT_LENGTH-1 -: FLIT_DATA_LENGTH],
                  txn_id: r_txn};
    end
`else
    always_comb begin
        w_flit = w_head.flit;
        w_rec  = '{src_id: node_id_i,
                   flit_data: w_head.flit[FLIT_LENGTH-1 -: FLIT_DATA_LENGTH]};
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int v = 0; v < VC_NUM; v++) r_credit[v] <= CRD_MAX;
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_credit <= w_crd_nxt;
            r_err    <= r_err || w_err_evt;
            if (w_disp) r_rr_ptr <= (32'(w_vc) == 32'(VC_NUM - 1)) ? '0 : w_vc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_v    <= 1'b0;
            r_tx_flit <= '0;
            r_tx_vc   <= '0;
            r_tx_la   <= PORT_N;
            r_rec     <= '0;
        end else begin
            r_tx_v <= w_disp;
            if (w_disp) begin
                r_tx_flit <= w_flit;
                r_tx_vc   <= w_vc;
                r_tx_la   <= w_head.la_routing;
                r_rec     <= w_rec;
            end
        end
    end

    assign tx_flit_pend_o               = !w_empty;
    assign tx_flit_v_o                  = r_tx_v;
    assign tx_flit_o                    = r_tx_flit;
    assign tx_flit_vc_id_o              = r_tx_vc;
    assign tx_flit_look_ahead_routing_o = r_tx_la;
    assign record_scoreboard_vld_o      = r_tx_v;
    assign record_scoreboard_o          = r_rec;
    assign idle_o                       = w_empty && w_crd_full && !r_tx_v;
    assign err_o                        = r_err;
endmodule

// File: tb/tb_v_sender.sv
// tb_v_sender: randomized self-checking bench for v_sender against a queue/credit reference model.
// Define V_SENDER_TXN_ID_EN to also exercise the transaction-id stamping.
module tb_v_sender;
    import v_noc_pkg::*;

    localparam int VC_NUM   = 4;
    localparam int VC_DEPTH = 2;
    localparam int QD       = 4;

    logic                       clk = 1'b0;
    logic                       rstn = 1'b0;
    logic                       gen_req_vld_i = 1'b0;
    logic                       gen_req_rdy_o;
    flit_payload_t              gen_req_flit_i = '0;
    logic [VC_NUM-1:0]          gen_req_vc_mask_i = '0;
    io_port_t                   gen_req_look_ahead_routing_i = PORT_N;
    logic                       tx_flit_pend_o;
    logic                       tx_flit_v_o;
    flit_payload_t              tx_flit_o;
    logic [VC_ID_NUM_MAX_W-1:0] tx_flit_vc_id_o;
    io_port_t                   tx_flit_look_ahead_routing_o;
    logic                       tx_lcrd_v_i = 1'b0;
    logic [VC_ID_NUM_MAX_W-1:0] tx_lcrd_id_i = '0;
    logic                       record_scoreboard_vld_o;
    sender_info_t               record_scoreboard_o;
    logic                       record_scoreboard_rdy_i = 1'b0;
    node_id_t                   node_id_i = 4'hA;
    logic                       idle_o;
    logic                       err_o;

    v_sender #(.VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .REQ_FIFO_DEPTH(QD)) dut (
        .clk(clk), .rstn(rstn),
        .gen_req_vld_i(gen_req_vld_i), .gen_req_rdy_o(gen_req_rdy_o),
        .gen_req_flit_i(gen_req_flit_i), .gen_req_vc_mask_i(gen_req_vc_mask_i),
        .gen_req_look_ahead_routing_i(gen_req_look_ahead_routing_i),
        .tx_flit_pend_o(tx_flit_pend_o), .tx_flit_v_o(tx_flit_v_o), .tx_flit_o(tx_flit_o),
        .tx_flit_vc_id_o(tx_flit_vc_id_o),
        .tx_flit_look_ahead_routing_o(tx_flit_look_ahead_routing_o),
        .tx_lcrd_v_i(tx_lcrd_v_i), .tx_lcrd_id_i(tx_lcrd_id_i),
        .record_scoreboard_vld_o(record_scoreboard_vld_o),
        .record_scoreboard_o(record_scoreboard_o),
        .record_scoreboard_rdy_i(record_scoreboard_rdy_i),
        .node_id_i(node_id_i), .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model: FIFO contents, credits, round-robin pointer, sticky error
    sender_req_t mq[$];
    int          cm[VC_NUM];
    int          mptr;
    bit          merr;
    int          mtxn;
    bit          p_push;
    sender_req_t p_req;
    bit          p_lcrd_v;
    int          p_lcrd_id;
    bit          p_sbrdy;
    bit          echo;
    bit          rand_lcrd;
    int          seen_vc[$];
    int          seen_cyc[$];
    int          seen_txn[$];

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        gen_req_vld_i = 1'b0;
        tx_lcrd_v_i = 1'b0;
        record_scoreboard_rdy_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        mq.delete();
        for (int v = 0; v < VC_NUM; v++) cm[v] = VC_DEPTH;
        mptr = 0; merr = 0; mtxn = 0;
        p_push = 0; p_lcrd_v = 0; p_lcrd_id = 0; p_sbrdy = 0;
        echo = 0; rand_lcrd = 0;
        seen_vc.delete(); seen_cyc.delete(); seen_txn.delete();
    endtask

    // One clock: check what the DUT decided last cycle, advance the model, drive new inputs.
    task automatic step(input bit vld, input logic [VC_NUM-1:0] mask, input bit lv,
                        input int lid, input bit sbrdy);
        sender_req_t   req;
        bit            disp, drop, eidle;
        int            vc, k, v;
        flit_payload_t ef;
        @(negedge clk);
        cyc++;
        disp = 0; drop = 0; vc = 0;
        if (mq.size() > 0) begin
            if (mq[0].vc_mask[VC_NUM-1:0] == '0) drop = 1;
            else if (p_sbrdy)
                for (int i = 0; i < VC_NUM; i++) begin
                    k = (mptr + i) % VC_NUM;
                    if (!disp && mq[0].vc_mask[k] && cm[k] > 0) begin disp = 1; vc = k; end
                end
        end
        if (tx_flit_v_o === 1'b1) begin
            seen_vc.push_back(int'(tx_flit_vc_id_o));
            seen_cyc.push_back(cyc);
`ifdef V_SENDER_TXN_ID_EN
            seen_txn.push_back(int'(record_scoreboard_o.txn_id));
`endif
        end
        checks++;
        if (tx_flit_v_o !== disp) begin errors++; $display("FAIL tx_valid cyc %0d: got %b want %b", cyc, tx_flit_v_o, disp); end
        checks++;
        if (record_scoreboard_vld_o !== disp) begin errors++; $display("FAIL rec_valid cyc %0d: got %b want %b", cyc, record_scoreboard_vld_o, disp); end
        if (disp) begin
            ef = mq[0].flit;
`ifdef V_SENDER_TXN_ID_EN
            ef[TXN_ID_LSB +: SENDER_TXN_ID_W] = SENDER_TXN_ID_W'(mtxn);
            checks++;
            if (record_scoreboard_o.txn_id !== SENDER_TXN_ID_W'(mtxn)) begin errors++; $display("FAIL rec_txn: got %0d want %0d", record_scoreboard_o.txn_id, mtxn); end
`endif
            checks++;
            if (tx_flit_vc_id_o !== VC_ID_NUM_MAX_W'(vc)) begin errors++; $display("FAIL tx_vc cyc %0d: got %0d want %0d", cyc, tx_flit_vc_id_o, vc); end
            checks++;
            if (tx_flit_o !== ef) begin errors++; $display("FAIL tx_flit: got %h want %h", tx_flit_o, ef); end
            checks++;
            if (tx_flit_look_ahead_routing_o !== mq[0].la_routing) begin errors++; $display("FAIL tx_la: got %0d want %0d", tx_flit_look_ahead_routing_o, mq[0].la_routing); end
            checks++;
            if (record_scoreboard_o.src_id !== node_id_i) begin errors++; $display("FAIL rec_src: got %h want %h", record_scoreboard_o.src_id, node_id_i); end
            checks++;
            if (record_scoreboard_o.flit_data !== ef[FLIT_LENGTH-1 -: FLIT_DATA_LENGTH]) begin errors++; $display("FAIL rec_data: got %h want %h", record_scoreboard_o.flit_data, ef[FLIT_LENGTH-1 -: FLIT_DATA_LENGTH]); end
        end
        if (disp || drop) void'(mq.pop_front());
        if (drop) merr = 1;
        if (p_lcrd_v) begin
            if (p_lcrd_id >= VC_NUM) merr = 1;
            else if (cm[p_lcrd_id] == VC_DEPTH && !(disp && vc == p_lcrd_id)) merr = 1;
            else cm[p_lcrd_id]++;
        end
        if (disp) begin
            cm[vc]--;
            mptr = (vc + 1) % VC_NUM;
            mtxn = (mtxn + 1) % (1 << SENDER_TXN_ID_W);
        end
        if (p_push) mq.push_back(p_req);
        eidle = (mq.size() == 0) && !disp;
        for (int i = 0; i < VC_NUM; i++) if (cm[i] != VC_DEPTH) eidle = 0;
        checks++;
        if (tx_flit_pend_o !== (mq.size() > 0)) begin errors++; $display("FAIL pend cyc %0d: got %b want %b", cyc, tx_flit_pend_o, mq.size() > 0); end
        checks++;
        if (err_o !== merr) begin errors++; $display("FAIL err cyc %0d: got %b want %b", cyc, err_o, merr); end
        checks++;
        if (idle_o !== eidle) begin errors++; $display("FAIL idle cyc %0d: got %b want %b", cyc, idle_o, eidle); end
        if (echo && disp) begin lv = 1; lid = vc; end
        else if (rand_lcrd && !lv && $urandom_range(0, 1) == 1) begin
            v = $urandom_range(0, VC_NUM - 1);
            if (cm[v] < VC_DEPTH) begin lv = 1; lid = v; end
        end
        for (int i = 0; i < FLIT_LENGTH / 32; i++) req.flit[i*32 +: 32] = $urandom();
        req.vc_mask    = VC_NUM_MAX'(mask);
        req.la_routing = io_port_t'($urandom_range(0, 4));
        gen_req_vld_i                = vld;
        gen_req_flit_i               = req.flit;
        gen_req_vc_mask_i            = mask;
        gen_req_look_ahead_routing_i = req.la_routing;
        tx_lcrd_v_i                  = lv;
        tx_lcrd_id_i                 = VC_ID_NUM_MAX_W'(lid);
        record_scoreboard_rdy_i      = sbrdy;
        #1;
        if (mq.size() < QD) begin
            checks++;
            if (gen_req_rdy_o !== 1'b1) begin errors++; $display("FAIL rdy cyc %0d: got %b want 1", cyc, gen_req_rdy_o); end
        end else if (!sbrdy && mq[0].vc_mask[VC_NUM-1:0] != '0) begin
            checks++;
            if (gen_req_rdy_o !== 1'b0) begin errors++; $display("FAIL rdy_full cyc %0d: got %b want 0", cyc, gen_req_rdy_o); end
        end
        p_push = vld && (gen_req_rdy_o === 1'b1);
        p_req = req; p_lcrd_v = lv; p_lcrd_id = lid; p_sbrdy = sbrdy;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 1);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (gen_req_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", gen_req_rdy_o); end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle_o); end
        checks++; if (tx_flit_v_o !== 1'b0) begin errors++; $display("FAIL reset_txv: got %b want 0", tx_flit_v_o); end
        checks++; if (tx_flit_o !== '0) begin errors++; $display("FAIL reset_flit: got %h want 0", tx_flit_o); end
        checks++; if (tx_flit_pend_o !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", tx_flit_pend_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
        checks++; if (record_scoreboard_vld_o !== 1'b0) begin errors++; $display("FAIL reset_recv: got %b want 0", record_scoreboard_vld_o); end
        idle_steps(2);
    endtask

    task automatic test_single();
        int c0;
        do_reset();
        step(1, 4'b0001, 0, 0, 1);
        c0 = cyc;
        idle_steps(4);
        checks++;
        if (seen_cyc.size() != 1 || seen_cyc[0] != c0 + 2) begin errors++; $display("FAIL single_latency: got %0d flits, first at +%0d want 1 at +2", seen_cyc.size(), seen_cyc.size() > 0 ? seen_cyc[0] - c0 : -1); end
        checks++;
        if (idle_o !== 1'b0) begin errors++; $display("FAIL single_credit_out: idle got %b want 0", idle_o); end
    endtask

    task automatic test_credit_stall();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 4'b0001, 0, 0, 1);
        idle_steps(5);
        checks++;
        if (seen_vc.size() != 2) begin errors++; $display("FAIL stall_count: got %0d want 2", seen_vc.size()); end
        checks++;
        if (tx_flit_pend_o !== 1'b1) begin errors++; $display("FAIL stall_pend: got %b want 1", tx_flit_pend_o); end
        step(0, '0, 1, 0, 1);
        idle_steps(3);
        checks++;
        if (seen_vc.size() != 3 || seen_cyc[2] != seen_cyc[1] + 7) begin errors++; $display("FAIL stall_resume: got %0d flits want 3 at lcrd+2", seen_vc.size()); end
        step(0, '0, 1, 0, 1);
        step(0, '0, 1, 0, 1);
        idle_steps(2);
    endtask

    task automatic test_round_robin();
        int want[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset();
        echo = 1;
        for (int i = 0; i < 8; i++) step(1, 4'b1111, 0, 0, 1);
        idle_steps(6);
        checks++;
        if (seen_vc.size() != 8) begin errors++; $display("FAIL rr_count: got %0d want 8", seen_vc.size()); end
        else for (int i = 0; i < 8; i++) begin
            checks++;
            if (seen_vc[i] != want[i]) begin errors++; $display("FAIL rr_seq[%0d]: got %0d want %0d", i, seen_vc[i], want[i]); end
        end
    endtask

    task automatic test_same_cycle_credit();
        do_reset();
        step(1, 4'b0001, 0, 0, 1);
        idle_steps(2);
        step(1, 4'b0001, 0, 0, 1);
        step(0, '0, 1, 0, 1);
        idle_steps(2);
        checks++;
        if (err_o !== 1'b0 || idle_o !== 1'b0) begin errors++; $display("FAIL same_cycle: err %b idle %b want 0 0", err_o, idle_o); end
        step(0, '0, 1, 0, 1);
        idle_steps(1);
        checks++;
        if (idle_o !== 1'b1) begin errors++; $display("FAIL credit_home: idle got %b want 1", idle_o); end
        step(0, '0, 1, 0, 1);
        idle_steps(1);
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL spurious_lcrd: err got %b want 1", err_o); end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        for (int i = 0; i < 6; i++) step(1, VC_NUM'($urandom_range(1, 15)), 0, 0, 0);
        n = seen_vc.size();
        for (int i = 0; i < 5; i++) step(1, 4'b1111, 0, 0, 0);
        checks++;
        if (seen_vc.size() != 0 || n != 0) begin errors++; $display("FAIL bp_no_tx: got %0d flits want 0", seen_vc.size()); end
        echo = 1;
        idle_steps(14);
        checks++;
        if (seen_vc.size() != QD || idle_o !== 1'b1) begin errors++; $display("FAIL bp_drain: got %0d flits idle %b want %0d 1", seen_vc.size(), idle_o, QD); end
    endtask

    task automatic test_random();
        logic [VC_NUM-1:0] m;
        do_reset();
        rand_lcrd = 1;
        for (int i = 0; i < 300; i++) begin
            m = VC_NUM'($urandom_range(1, 15));
            if ($urandom_range(0, 40) == 0) m = '0;
            step($urandom_range(0, 9) < 6, m, 0, 0, $urandom_range(0, 9) < 8);
        end
        for (int i = 0; i < 40; i++) step(0, '0, 0, 0, 1);
    endtask

    task automatic test_midreset();
        do_reset();
        step(1, 4'b0011, 0, 0, 0);
        step(1, 4'b0100, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        do_reset();
        #1;
        checks++;
        if (idle_o !== 1'b1 || tx_flit_pend_o !== 1'b0) begin errors++; $display("FAIL midreset: idle %b pend %b want 1 0", idle_o, tx_flit_pend_o); end
        idle_steps(5);
        checks++;
        if (seen_vc.size() != 0) begin errors++; $display("FAIL midreset_tx: got %0d flits want 0", seen_vc.size()); end
        echo = 1;
        for (int i = 0; i < 4; i++) step(1, 4'b0001, 0, 0, 1);
        idle_steps(4);
        checks++;
        if (seen_vc.size() != 4) begin errors++; $display("FAIL midreset_credits: got %0d flits want 4", seen_vc.size()); end
    endtask

`ifdef V_SENDER_TXN_ID_EN
    task automatic test_txn();
        do_reset();
        echo = 1;
        for (int i = 0; i < 17; i++) step(1, 4'b1111, 0, 0, 1);
        idle_steps(6);
        checks++;
        if (seen_txn.size() != 17) begin errors++; $display("FAIL txn_count: got %0d want 17", seen_txn.size()); end
        else for (int i = 0; i < 17; i++) begin
            checks++;
            if (seen_txn[i] != i % 16) begin errors++; $display("FAIL txn_seq[%0d]: got %0d want %0d", i, seen_txn[i], i % 16); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_credit_stall();
        test_round_robin();
        test_same_cycle_credit();
        test_backpressure();
        test_random();
        test_midreset();
`ifdef V_SENDER_TXN_ID_EN
        test_txn();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
